// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - start/busy/done handshake and result bundle for div_seq
// DIV_OVF_FLAG_EN adds the ovf result flag.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
`ifdef DIV_OVF_FLAG_EN
  logic             ovf;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, ovf
  );
  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, ovf
  );
`else
  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`endif
endinterface

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle restoring divider, quotient -> LO, remainder -> HI
// DIV_OVF_FLAG_EN adds the signed MIN / -1 overflow flag (ovf).
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  div_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      sgn_q         <= 1'b0;
      qneg_q        <= 1'b0;
      rneg_q        <= 1'b0;
      dvs_q         <= '0;
      dvd_q         <= '0;
      prem_q        <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      sgn_q         <= sgn_d;
      qneg_q        <= qneg_d;
      rneg_q        <= rneg_d;
      dvs_q         <= dvs_d;
      dvd_q         <= dvd_d;
      prem_q        <= prem_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      ovf_q         <= ovf_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    sgn_d         = sgn_q;
    qneg_d        = qneg_q;
    rneg_d        = rneg_q;
    dvs_d         = dvs_q;
    dvd_d         = dvd_q;
    prem_d        = prem_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    ovf_d         = ovf_q;
    // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom
    shifted       = {prem_q, dvd_q[WIDTH-1]};
    trial         = shifted - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.dividend;
          b_d     = bus.divisor;
          sgn_d   = bus.signed_op;
          busy_d  = 1'b1;
          state_d = PREP;
        end
      end
      PREP: begin
        dvd_d  = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        dvs_d  = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        qneg_d = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d = sgn_q && a_q[WIDTH-1];
        prem_d = '0;
        cnt_d  = CNT_W'(WIDTH);
        if (b_q == '0) begin
          done_d        = 1'b1;
          busy_d        = 1'b0;
          quotient_d    = '1;
          remainder_d   = a_q;
          div_by_zero_d = 1'b1;
          ovf_d         = 1'b0;
          state_d       = IDLE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        if (!trial[WIDTH]) begin
          prem_d = trial[WIDTH-1:0];
          dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_d = shifted[WIDTH-1:0];
          dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // MIN / -1 needs no special path: the magnitude quotient is already the MIN pattern
        quotient_d    = qneg_q ? -dvd_q : dvd_q;
        remainder_d   = rneg_q ? -prem_q : prem_q;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        div_by_zero_d = 1'b0;
        ovf_d         = sgn_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;
`ifdef DIV_OVF_FLAG_EN
  assign bus.ovf         = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq (vector table, corner sequences, random vs model)
module tb_div_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(W)) bus ();
  div_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dbz, output logic ovf);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dbz = (b == 32'd0);
    ovf = 1'b0;
    if (dbz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      ovf = (sa / sb) > 64'sd2147483647;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.signed_op = s;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.signed_op = 1'($urandom);
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_bad);
    lat = -1;
    busy_bad = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        if (bus.busy) busy_bad++;
        break;
      end
      if (!bus.busy) busy_bad++;
    end
  endtask

  task automatic exercise(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input logic dbz, input logic ovf);
    int lat, bb;
    start_op(s, a, b);
    check({tag, " busy after start"}, 32'(bus.busy), 32'd1);
    wait_done(lat, bb);
    check({tag, " latency"}, 32'(lat), (b == 32'd0) ? 32'd1 : 32'd34);
    check({tag, " busy profile"}, 32'(bb), 32'd0);
    check({tag, " quotient"}, bus.quotient, q);
    check({tag, " remainder"}, bus.remainder, r);
    check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(dbz));
`ifdef DIV_OVF_FLAG_EN
    check({tag, " ovf"}, 32'(bus.ovf), 32'(ovf));
`else
    if (ovf === 1'bx) $display("note: unknown ovf expectation for %s", tag);
`endif
    @(posedge clk); #1;
    check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
    check({tag, " quotient held"}, bus.quotient, q);
  endtask

  initial begin
    int lat, bb, dcnt;
    logic s, dbz, ovf;
    logic [31:0] a, b, q, r;

    bus.start = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;

    tbl[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, 1'b0};
    tbl[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 1'b1};
    tbl[4]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'h1234,      32'd0,         32'hFFFFFFFF,  32'h1234,      1'b1, 1'b0};
    tbl[6]  = '{1'b0, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0, 1'b0};
    tbl[7]  = '{1'b1, 32'h1234,      32'd0,         32'hFFFFFFFF,  32'h1234,      1'b1, 1'b0};
    tbl[8]  = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0, 1'b0};
    tbl[10] = '{1'b0, 32'd5,         32'd9,         32'd0,         32'd5,         1'b0, 1'b0};
    tbl[11] = '{1'b1, 32'd7,         32'h80000000,  32'd0,         32'd7,         1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset quotient", bus.quotient, 32'd0);
    check("reset remainder", bus.remainder, 32'd0);
    check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      exercise($sformatf("vec%0d", i), tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
               tbl[i].dbz, tbl[i].ovf);
    end

    start_op(1'b0, 32'hFFFFFFFF, 32'd1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b1;
    bus.signed_op = 1'b0;
    bus.dividend = 32'd6;
    bus.divisor = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, bb);
    check("ignored start latency", 32'(lat), 32'd29);
    check("ignored start busy", 32'(bb), 32'd0);
    check("ignored start quotient", bus.quotient, 32'hFFFFFFFF);
    check("ignored start remainder", bus.remainder, 32'd0);
    start_op(1'b0, 32'd6, 32'd2);
    check("done-cycle start busy", 32'(bus.busy), 32'd1);
    check("done-cycle held quotient", bus.quotient, 32'hFFFFFFFF);
    wait_done(lat, bb);
    check("done-cycle start latency", 32'(lat), 32'd34);
    check("done-cycle start quotient", bus.quotient, 32'd3);
    check("done-cycle start remainder", bus.remainder, 32'd0);

    start_op(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort quotient", bus.quotient, 32'd0);
    check("abort remainder", bus.remainder, 32'd0);
    check("abort div_by_zero", 32'(bus.div_by_zero), 32'd0);
    dcnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
    check("abort no done pulse", 32'(dcnt), 32'd0);
    exercise("after reset 50/5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFFFFFF - 32'($urandom_range(0, 14));
        3: begin a = 32'h80000000; b = (i % 2 == 0) ? 32'hFFFFFFFF : $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      model(s, a, b, q, r, dbz, ovf);
      exercise($sformatf("rnd%0d", i), s, a, b, q, r, dbz, ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
